// File: rtl/bcd_pkg.sv
// Shared types and encodings for the digit-serial BCD add/subtract datapath.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    NEG,
    SHIFT,
    DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of add (x+y+cin) or subtract (x-y-cin) with decimal carry/borrow out.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t digit,
  output logic       cout
);

  logic [4:0] s;
  logic [4:0] t;

  // Binary add/sub of the digits, then a decimal correction by +/-10.
  // Subtract range is -10..9, so bit 4 of the 5-bit result is the sign.
  always_comb begin
    s     = '0;
    t     = '0;
    digit = '0;
    cout  = 1'b0;
    if (sub) begin
      s = {1'b0, x} - {1'b0, y} - {4'd0, cin};
      if (s[4]) begin
        t     = s + 5'd10;
        digit = t[3:0];
        cout  = 1'b1;
      end else begin
        digit = s[3:0];
      end
    end else begin
      s = {1'b0, x} + {1'b0, y} + {4'd0, cin};
      if (s > {1'b0, BCD_MAX}) begin
        t     = s - 5'd10;
        digit = t[3:0];
        cout  = 1'b1;
      end else begin
        digit = s[3:0];
      end
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor, LSD first, with sign-magnitude subtract
// and an optional MSB-first bit-serial result stream.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit SER_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                carry_out,
  output logic                neg,
  output logic                invalid,
  output logic                ser_out,
  output logic                ser_valid,
  output logic                ser_last
);

  localparam int W  = 4 * DIGITS;
  localparam int DW = $clog2(DIGITS + 1);
  localparam int BW = $clog2(W + 1);

  state_t         state;
  logic           op_r;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-1:0]   work;
  logic           cb;       // carry (add) or borrow (sub / complement) between digits
  logic           neg_r;
  logic [DW-1:0]  dcnt;
  logic [BW-1:0]  bcnt;

  bcd_digit_t     ux, uy, udig;
  logic           usub, ucout;
  logic [W-1:0]   work_nxt;
  logic           in_bad;
  logic [W-1:0]   ser_sh;

  // Single digit unit: operands in CALC, 0 - r_k for the in-place complement in NEG.
  always_comb begin
    ux   = a_sh[3:0];
    uy   = b_sh[3:0];
    usub = op_r;
    if (state == NEG) begin
      ux   = '0;
      uy   = work[3:0];
      usub = 1'b1;
    end
  end

  bcd_digit_addsub u_digit (
    .x     (ux),
    .y     (uy),
    .cin   (cb),
    .sub   (usub),
    .digit (udig),
    .cout  (ucout)
  );

  // Work register rotates right one digit per step; the new digit enters at the top,
  // so after DIGITS steps the digits sit back in their natural positions.
  always_comb begin
    work_nxt = (work >> 4) | (W'(udig) << (W - 4));
  end

  // Flag any non-BCD nibble on the incoming operands.
  always_comb begin
    in_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] > BCD_MAX || b[4*k +: 4] > BCD_MAX) in_bad = 1'b1;
    end
  end

  // Sequencer: accept, digit loop, optional complement, optional serial shift, done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_r      <= OP_ADD;
      a_sh      <= '0;
      b_sh      <= '0;
      work      <= '0;
      cb        <= 1'b0;
      neg_r     <= 1'b0;
      dcnt      <= '0;
      bcnt      <= '0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      neg       <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            a_sh  <= a;
            b_sh  <= b;
            work  <= '0;
            cb    <= 1'b0;
            neg_r <= 1'b0;
            dcnt  <= '0;
            bcnt  <= '0;
            if (in_bad) begin
              state     <= DONE;
              done      <= 1'b1;
              result    <= '0;
              carry_out <= 1'b0;
              neg       <= 1'b0;
              invalid   <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          work <= work_nxt;
          cb   <= ucout;
          dcnt <= dcnt + 1'b1;
          if (dcnt == DW'(DIGITS - 1)) begin
            dcnt <= '0;
            if (op_r == OP_SUB && ucout) begin
              state <= NEG;
              cb    <= 1'b0;
              neg_r <= 1'b1;
            end else if (SER_EN) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              done      <= 1'b1;
              result    <= work_nxt;
              carry_out <= (op_r == OP_ADD) & ucout;
              neg       <= 1'b0;
              invalid   <= 1'b0;
            end
          end
        end
        NEG: begin
          work <= work_nxt;
          cb   <= ucout;
          dcnt <= dcnt + 1'b1;
          if (dcnt == DW'(DIGITS - 1)) begin
            dcnt <= '0;
            if (SER_EN) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              done      <= 1'b1;
              result    <= work_nxt;
              carry_out <= 1'b0;
              neg       <= 1'b1;
              invalid   <= 1'b0;
            end
          end
        end
        SHIFT: begin
          bcnt <= bcnt + 1'b1;
          if (bcnt == BW'(W - 1)) begin
            bcnt      <= '0;
            state     <= DONE;
            done      <= 1'b1;
            result    <= work;
            carry_out <= (op_r == OP_ADD) & cb;
            neg       <= neg_r;
            invalid   <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Serial stream is a decode of the held work register, MSB first.
  always_comb begin
    ser_sh    = work << bcnt;
    ser_valid = SER_EN && (state == SHIFT);
    ser_out   = ser_valid & ser_sh[W-1];
    ser_last  = ser_valid && (bcnt == BW'(W - 1));
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: directed cases plus randomized ops against a
// decimal-arithmetic reference model. Two instances: serial enabled / disabled.
module tb_bcd_serial_addsub;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic        op = 1'b0;
  logic [15:0] a = '0, b = '0;

  logic        busy1, done1, cy1, ng1, inv1, so1, sv1, sl1;
  logic        busy0, done0, cy0, ng0, inv0, so0, sv0, sl0;
  logic [15:0] res1, res0;

  int n_cmp = 0;
  int n_fail = 0;
  int sv0_seen = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(4), .SER_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(res1), .carry_out(cy1), .neg(ng1),
    .invalid(inv1), .ser_out(so1), .ser_valid(sv1), .ser_last(sl1));

  bcd_serial_addsub #(.DIGITS(4), .SER_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op(op), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(res0), .carry_out(cy0), .neg(ng0),
    .invalid(inv0), .ser_out(so0), .ser_valid(sv0), .ser_last(sl0));

  // Serial-disabled instance must never raise ser_valid.
  always @(negedge clk) if (sv0 || sl0 || so0) sv0_seen++;

  // ---------------- reference model ----------------
  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int k = 3; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = '0;
    int m = n;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic model(input bit ser, input bit op_i, input logic [15:0] a_i, b_i,
                       output logic [15:0] r, output logic cy, ng, inv, output int lat);
    int x, y;
    inv = 1'b0;
    for (int k = 0; k < 4; k++) if (a_i[4*k +: 4] > 9 || b_i[4*k +: 4] > 9) inv = 1'b1;
    r = '0; cy = 1'b0; ng = 1'b0;
    if (inv) begin
      lat = 1;
      return;
    end
    x = bcd2int(a_i);
    y = bcd2int(b_i);
    if (!op_i) begin
      r  = int2bcd((x + y) % 10000);
      cy = (x + y) >= 10000;
    end else if (x >= y) begin
      r = int2bcd(x - y);
    end else begin
      r  = int2bcd(y - x);
      ng = 1'b1;
    end
    lat = 4 + (ng ? 4 : 0) + (ser ? 16 : 0) + 1;
  endtask

  // ---------------- stimulus / observation ----------------
  // Issues one op to the chosen instance, then records what comes back.
  task automatic run_op(input bit ser, input bit op_i, input logic [15:0] a_i, b_i,
                        output int lat, output logic [15:0] r, output logic cy, ng, inv,
                        output logic [15:0] sbits, output int nser, output int nlast,
                        output bit lastbad);
    lat = -1; r = '0; cy = 0; ng = 0; inv = 0; sbits = '0; nser = 0; nlast = 0; lastbad = 0;
    @(negedge clk);
    op = op_i; a = a_i; b = b_i;
    if (ser) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; start0 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (ser) begin
        if (sv1) begin
          sbits = {sbits[14:0], so1};
          nser++;
          if (sl1) begin
            nlast++;
            if (nser != 16) lastbad = 1;
          end
        end else if (sl1) lastbad = 1;
        if (done1) begin lat = c; r = res1; cy = cy1; ng = ng1; inv = inv1; break; end
      end else begin
        if (done0) begin lat = c; r = res0; cy = cy0; ng = ng0; inv = inv0; break; end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy1, done1); end
    n_cmp++; if (res1 !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0000", res1); end
    n_cmp++; if ({cy1, ng1, inv1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {cy1, ng1, inv1}); end
    n_cmp++; if ({so1, sv1, sl1} !== 3'b000) begin n_fail++; $display("FAIL reset_serial: got %b want 000", {so1, sv1, sl1}); end
    n_cmp++; if ({busy0, done0, res0} !== 18'h0) begin n_fail++; $display("FAIL reset_nosr: got %b %b %h want 0 0 0000", busy0, done0, res0); end
    reset = 1'b0;
  endtask

  task automatic test_add;
    int lat, ns, nl; logic [15:0] r, sb; logic cy, ng, inv; bit lb;
    run_op(1, 1'b0, 16'h1234, 16'h5678, lat, r, cy, ng, inv, sb, ns, nl, lb);
    n_cmp++; if (lat != 21) begin n_fail++; $display("FAIL add_latency: got %0d want 21", lat); end
    n_cmp++; if (r !== 16'h6912) begin n_fail++; $display("FAIL add_result: got %h want 6912", r); end
    n_cmp++; if ({cy, ng, inv} !== 3'b000) begin n_fail++; $display("FAIL add_flags: got %b want 000", {cy, ng, inv}); end
    n_cmp++; if (sb !== 16'b0110_1001_0001_0010 || ns != 16) begin n_fail++; $display("FAIL add_serial: got %b/%0d want 0110100100010010/16", sb, ns); end
    n_cmp++; if (nl != 1 || lb) begin n_fail++; $display("FAIL add_ser_last: got count %0d misplaced %0d want 1 0", nl, lb); end
  endtask

  task automatic test_overflow;
    int lat, ns, nl; logic [15:0] r, sb; logic cy, ng, inv; bit lb;
    run_op(1, 1'b0, 16'h9999, 16'h0001, lat, r, cy, ng, inv, sb, ns, nl, lb);
    n_cmp++; if (r !== 16'h0000 || cy !== 1'b1) begin n_fail++; $display("FAIL ovf_result: got %h c%b want 0000 c1", r, cy); end
    n_cmp++; if (lat != 21) begin n_fail++; $display("FAIL ovf_latency: got %0d want 21", lat); end
    run_op(0, 1'b0, 16'h9999, 16'h0001, lat, r, cy, ng, inv, sb, ns, nl, lb);
    n_cmp++; if (r !== 16'h0000 || cy !== 1'b1) begin n_fail++; $display("FAIL ovf_noser_result: got %h c%b want 0000 c1", r, cy); end
    n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL ovf_noser_latency: got %0d want 5", lat); end
  endtask

  task automatic test_sub;
    int lat, ns, nl; logic [15:0] r, sb; logic cy, ng, inv; bit lb;
    run_op(1, 1'b1, 16'h0500, 16'h0123, lat, r, cy, ng, inv, sb, ns, nl, lb);
    n_cmp++; if (r !== 16'h0377 || ng !== 1'b0 || cy !== 1'b0) begin n_fail++; $display("FAIL sub_pos: got %h n%b c%b want 0377 n0 c0", r, ng, cy); end
    n_cmp++; if (lat != 21) begin n_fail++; $display("FAIL sub_pos_latency: got %0d want 21", lat); end
    run_op(1, 1'b1, 16'h0123, 16'h0500, lat, r, cy, ng, inv, sb, ns, nl, lb);
    n_cmp++; if (r !== 16'h0377 || ng !== 1'b1 || cy !== 1'b0) begin n_fail++; $display("FAIL sub_neg: got %h n%b c%b want 0377 n1 c0", r, ng, cy); end
    n_cmp++; if (lat != 25) begin n_fail++; $display("FAIL sub_neg_latency: got %0d want 25", lat); end
    n_cmp++; if (sb !== 16'h0377) begin n_fail++; $display("FAIL sub_neg_serial: got %h want 0377", sb); end
    run_op(1, 1'b1, 16'h4321, 16'h4321, lat, r, cy, ng, inv, sb, ns, nl, lb);
    n_cmp++; if (r !== 16'h0 || ng !== 1'b0 || lat != 21) begin n_fail++; $display("FAIL sub_equal: got %h n%b lat %0d want 0000 n0 21", r, ng, lat); end
  endtask

  task automatic test_invalid;
    int lat, ns, nl; logic [15:0] r, sb; logic cy, ng, inv; bit lb;
    run_op(1, 1'b0, 16'h12A4, 16'h0001, lat, r, cy, ng, inv, sb, ns, nl, lb);
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL inv_latency: got %0d want 1", lat); end
    n_cmp++; if (inv !== 1'b1 || r !== 16'h0 || cy !== 1'b0 || ng !== 1'b0) begin n_fail++; $display("FAIL inv_outputs: got i%b %h c%b n%b want i1 0000 c0 n0", inv, r, cy, ng); end
    n_cmp++; if (ns != 0) begin n_fail++; $display("FAIL inv_serial: got %0d bits want 0", ns); end
    run_op(1, 1'b0, 16'h0002, 16'h0003, lat, r, cy, ng, inv, sb, ns, nl, lb);
    n_cmp++; if (inv !== 1'b0 || r !== 16'h0005) begin n_fail++; $display("FAIL inv_clear: got i%b %h want i0 0005", inv, r); end
  endtask

  task automatic test_busy_reset;
    int lat, ns, nl, c, sc; logic [15:0] r, sb; logic cy, ng, inv; bit lb, hit;
    // start pulsed mid-CALC must not disturb the running op
    @(negedge clk);
    op = 1'b0; a = 16'h1111; b = 16'h2222; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    op = 1'b1; a = 16'h9999; b = 16'h0000; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    hit = 0;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done1) begin hit = 1; break; end
    end
    n_cmp++; if (!hit || res1 !== 16'h3333 || ng1 !== 1'b0) begin n_fail++; $display("FAIL busy_ignore: got done%0d %h n%b want done1 3333 n0", hit, res1, ng1); end
    // start during the DONE cycle is not queued
    start1 = 1'b1; op = 1'b0; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: got busy %b want 0", busy1); end
    // reset in SHIFT cycle 5 aborts
    @(negedge clk);
    op = 1'b0; a = 16'h4444; b = 16'h1111; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    sc = 0; hit = 0;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sv1) begin
        if (sc == 5) begin hit = 1; reset = 1'b1; break; end
        sc++;
      end
    end
    @(negedge clk);
    n_cmp++; if (!hit || busy1 !== 1'b0 || sv1 !== 1'b0 || res1 !== 16'h0) begin n_fail++; $display("FAIL mid_reset: got hit%0d busy%b sv%b %h want 1 0 0 0000", hit, busy1, sv1, res1); end
    reset = 1'b0;
    run_op(1, 1'b0, 16'h0808, 16'h0202, lat, r, cy, ng, inv, sb, ns, nl, lb);
    n_cmp++; if (r !== 16'h1010 || lat != 21 || sb !== 16'h1010) begin n_fail++; $display("FAIL after_reset: got %h lat %0d ser %h want 1010 21 1010", r, lat, sb); end
  endtask

  task automatic test_random;
    int lat, ns, nl, elat; logic [15:0] r, sb, er, ra, rb; logic cy, ng, inv, ecy, eng, einv; bit lb, rop, ser;
    for (int i = 0; i < 40; i++) begin
      ra = '0; rb = '0;
      for (int k = 0; k < 4; k++) begin
        ra[4*k +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) rb = ra;
      rop = 1'($urandom);
      ser = ($urandom_range(0, 3) != 0);
      model(ser, rop, ra, rb, er, ecy, eng, einv, elat);
      run_op(ser, rop, ra, rb, lat, r, cy, ng, inv, sb, ns, nl, lb);
      n_cmp++;
      if (lat != elat || r !== er || cy !== ecy || ng !== eng || inv !== einv) begin
        n_fail++;
        $display("FAIL rand_%0d op%0d %h,%h: got %h c%b n%b i%b lat%0d want %h c%b n%b i%b lat%0d",
                 i, rop, ra, rb, r, cy, ng, inv, lat, er, ecy, eng, einv, elat);
      end
      if (ser) begin
        n_cmp++;
        if (ns != (einv ? 0 : 16) || (!einv && (sb !== er || nl != 1 || lb))) begin
          n_fail++;
          $display("FAIL rand_serial_%0d: got %h/%0d last%0d bad%0d want %h/%0d", i, sb, ns, nl, lb, er, einv ? 0 : 16);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_invalid();
    test_busy_reset();
    test_random();
    n_cmp++; if (sv0_seen != 0) begin n_fail++; $display("FAIL noser_outputs: got %0d active cycles want 0", sv0_seen); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
